// File: rtl/aes_pkg.sv
// Shared AES types: block/key words, core mode encoding and the request arbiter FSM states.
`timescale 1ns/1ps
package aes_pkg;

  typedef logic [127:0] aes_128;
  typedef logic [255:0] key_256;

  typedef enum logic [1:0] {
    NOOP    = 2'd0,
    ENC_128 = 2'd1,
    ENC_192 = 2'd2,
    ENC_256 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, else the lowest set request.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic            hi_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan leaves the lowest qualifying index in each candidate.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) >= ptr_i) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    any_o = |req_i;
    idx_o = hi_found ? hi_idx : lo_idx;
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = any_o && (idx_o == ID_W'(i));
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin scheduler sharing one AES core among NUM_REQ requesters.
// Define AES_REQ_ARB_TIMEOUT_EN to add the watchdog and the resp_err_o port.
`timescale 1ns/1ps
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  aes_128 [NUM_REQ-1:0]  req_data_i,
  input  key_256 [NUM_REQ-1:0]  req_key_i,
  input  mode_e  [NUM_REQ-1:0]  req_mode_i,
  output aes_128                core_data_o,
  output key_256                core_key_o,
  output mode_e                 core_mode_o,
  input  logic                  core_ready_i,
  input  logic                  core_valid_i,
  input  aes_128                core_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output aes_128                resp_data_o,
  output logic [ID_W-1:0]       resp_id_o
`ifdef AES_REQ_ARB_TIMEOUT_EN
  ,
  output logic                  resp_err_o
`endif
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  aes_128          data_q, data_d;
  key_256          key_q, key_d;
  mode_e           core_mode_q, core_mode_d;
  aes_128          resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

`ifdef AES_REQ_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // A NOOP request is never eligible, so it cannot stall the rotation.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (req_mode_i[i] != NOOP);
    end
  end

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    data_d      = data_q;
    key_d       = key_q;
    core_mode_d = core_mode_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    req_ready_o = '0;
`ifdef AES_REQ_ARB_TIMEOUT_EN
    cnt_d       = '0;
    err_d       = err_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          req_ready_o = pick_gnt;
          id_d        = pick_idx;
          data_d      = req_data_i[pick_idx];
          key_d       = req_key_i[pick_idx];
          core_mode_d = req_mode_i[pick_idx];
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (core_ready_i) begin
          core_mode_d = NOOP;
          state_d     = ARB_BUSY;
        end
`ifdef AES_REQ_ARB_TIMEOUT_EN
        else if (timeout) begin
          core_mode_d = NOOP;
          resp_data_d = '0;
          resp_id_d   = id_q;
          err_d       = 1'b1;
          state_d     = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_BUSY: begin
        if (core_valid_i) begin
          resp_data_d = core_data_i;
          resp_id_d   = id_q;
          state_d     = ARB_RESP;
`ifdef AES_REQ_ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (timeout) begin
          resp_data_d = '0;
          resp_id_d   = id_q;
          err_d       = 1'b1;
          state_d     = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ARB_RESP: begin
        if (resp_ready_i) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = ARB_IDLE;
`ifdef AES_REQ_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // The accept strobe is combinational from req_valid_i; keep it quiet while reset holds.
    if (rst) req_ready_o = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      key_q       <= '0;
      core_mode_q <= NOOP;
      resp_data_q <= '0;
      resp_id_q   <= '0;
`ifdef AES_REQ_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      key_q       <= key_d;
      core_mode_q <= core_mode_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
`ifdef AES_REQ_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign core_data_o  = data_q;
  assign core_key_o   = key_q;
  assign core_mode_o  = core_mode_q;
  assign resp_valid_o = (state_q == ARB_RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
`ifdef AES_REQ_ARB_TIMEOUT_EN
  assign resp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: behavioural AES core stand-in plus a transaction-level arbiter model.
`timescale 1ns/1ps
module tb_aes_req_arbiter;
  import aes_pkg::*;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int TO   = 20;

  localparam aes_128 PT   = 128'h00112233445566778899aabbccddeeff;
  localparam key_256 K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam key_256 K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam key_256 K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam aes_128 C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam aes_128 C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam aes_128 C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid_i;
  logic [N-1:0]        req_ready_o;
  aes_128 [N-1:0]      req_data_i;
  key_256 [N-1:0]      req_key_i;
  mode_e  [N-1:0]      req_mode_i;
  aes_128              core_data_o;
  key_256              core_key_o;
  mode_e               core_mode_o;
  logic                core_ready_i;
  logic                core_valid_i;
  aes_128              core_data_i;
  logic                resp_valid_o;
  logic                resp_ready_i;
  aes_128              resp_data_o;
  logic [ID_W-1:0]     resp_id_o;
`ifdef AES_REQ_ARB_TIMEOUT_EN
  logic                resp_err_o;
`endif

  aes_req_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_key_i    (req_key_i),
    .req_mode_i   (req_mode_i),
    .core_data_o  (core_data_o),
    .core_key_o   (core_key_o),
    .core_mode_o  (core_mode_o),
    .core_ready_i (core_ready_i),
    .core_valid_i (core_valid_i),
    .core_data_i  (core_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_id_o    (resp_id_o)
`ifdef AES_REQ_ARB_TIMEOUT_EN
    ,
    .resp_err_o   (resp_err_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stand-in for the real cipher: known FIPS-197 answers, otherwise an operand-sensitive mix.
  function automatic aes_128 core_fn(aes_128 d, key_256 k, mode_e m);
    if (m == ENC_128 && d == PT && k == K128) return C128;
    if (m == ENC_192 && d == PT && k == K192) return C192;
    if (m == ENC_256 && d == PT && k == K256) return C256;
    return d ^ k[255:128] ^ {k[63:0], k[127:64]} ^ {126'b0, m};
  endfunction

  // Transaction-level model of the arbiter.
  logic         m_busy = 1'b0;
  int           m_ptr = 0;
  int           p_id;
  aes_128       p_data, p_exp;
  key_256       p_key;
  mode_e        p_mode;
  logic         p_err;
  logic         expect_to = 1'b0;
  logic [N-1:0] acc_mask = '0;
  int           acc_cnt [N];
  int           resp_cnt = 0;
  int           resp_order [$];
  aes_128       last_resp_data = '0;
  logic [N-1:0] exp_rdy;
  logic         busy_b;
  int           g, mc;

  initial begin
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_mask = '0;
      end else begin
        busy_b = m_busy;
        g = -1;
        if (!busy_b) begin
          for (int k = 0; k < N; k++) begin
            mc = (m_ptr + k) % N;
            if (g < 0 && req_valid_i[mc] && req_mode_i[mc] != NOOP) g = mc;
          end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        checks++;
        if (req_ready_o !== exp_rdy) begin
          errors++;
          $display("FAIL req_ready t=%0t got=%b exp=%b", $time, req_ready_o, exp_rdy);
        end
        acc_mask = exp_rdy;
        if (resp_valid_o) begin
          checks++;
          if (!busy_b) begin
            errors++;
            $display("FAIL spurious_resp t=%0t got resp_valid=1 exp=0", $time);
          end else begin
            checks += 2;
            if (resp_id_o !== ID_W'(p_id)) begin
              errors++;
              $display("FAIL resp_id t=%0t got=%0d exp=%0d", $time, resp_id_o, p_id);
            end
            if (resp_data_o !== p_exp) begin
              errors++;
              $display("FAIL resp_data t=%0t got=%h exp=%h", $time, resp_data_o, p_exp);
            end
`ifdef AES_REQ_ARB_TIMEOUT_EN
            checks++;
            if (resp_err_o !== p_err) begin
              errors++;
              $display("FAIL resp_err t=%0t got=%b exp=%b", $time, resp_err_o, p_err);
            end
`endif
            if (resp_ready_i) begin
              m_busy = 1'b0;
              m_ptr  = (p_id + 1) % N;
              last_resp_data = resp_data_o;
              resp_order.push_back(p_id);
              resp_cnt++;
            end
          end
        end
        if (g >= 0) begin
          m_busy = 1'b1;
          p_id   = g;
          p_data = req_data_i[g];
          p_key  = req_key_i[g];
          p_mode = req_mode_i[g];
          p_err  = expect_to;
          p_exp  = expect_to ? '0 : core_fn(p_data, p_key, p_mode);
          acc_cnt[g]++;
        end
      end
    end
  end

  // Behavioural core: random ready, random latency, optional spurious result pulses.
  logic   core_busy = 1'b0;
  logic   core_hold = 1'b0;
  logic   spur_en = 1'b0;
  int     core_cnt;
  aes_128 core_res;

  initial begin
    core_ready_i = 1'b0;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    forever begin
      @(negedge clk);
      core_valid_i = 1'b0;
      if (core_busy) begin
        core_ready_i = 1'b0;
        if (!core_hold) begin
          core_cnt--;
          if (core_cnt == 0) begin
            core_valid_i = 1'b1;
            core_data_i  = core_res;
            core_busy    = 1'b0;
          end
        end
      end else begin
        if (spur_en && $urandom_range(0, 9) == 0) begin
          core_valid_i = 1'b1;
          core_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        core_ready_i = ($urandom_range(0, 3) != 0);
        if (core_ready_i && core_mode_o != NOOP && !rst) begin
          checks++;
          if (core_data_o !== p_data || core_key_o !== p_key || core_mode_o !== p_mode) begin
            errors++;
            $display("FAIL core_operands t=%0t got=%h/%h/%0d exp=%h/%h/%0d", $time,
                     core_data_o, core_key_o, core_mode_o, p_data, p_key, p_mode);
          end
          core_res  = core_fn(core_data_o, core_key_o, core_mode_o);
          core_busy = 1'b1;
          core_cnt  = $urandom_range(1, 6);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=no finish exp=finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_mask[i]) req_valid_i[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input aes_128 d, input key_256 k, input mode_e m);
    req_data_i[i]  = d;
    req_key_i[i]   = k;
    req_mode_i[i]  = m;
    req_valid_i[i] = 1'b1;
  endtask

  task automatic rand_req(input int i, input mode_e m);
    key_256 k;
    k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    if (m == ENC_128) k[127:0] = '0;
    if (m == ENC_192) k[63:0] = '0;
    set_req(i, {$urandom(), $urandom(), $urandom(), $urandom()}, k, m);
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    for (int n = 0; n < budget && resp_cnt < target; n++) step();
    if (resp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=%0d responses exp=%0d", name, resp_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    resp_ready_i = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, PT, K128, ENC_128);
    repeat (3) @(negedge clk);
    checks += 7;
    if (req_ready_o !== '0) begin errors++; $display("FAIL rst_ready got=%b exp=0", req_ready_o); end
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid_o); end
    if (resp_data_o !== '0) begin errors++; $display("FAIL rst_resp_data got=%h exp=0", resp_data_o); end
    if (resp_id_o !== '0) begin errors++; $display("FAIL rst_resp_id got=%0d exp=0", resp_id_o); end
    if (core_mode_o !== NOOP) begin errors++; $display("FAIL rst_core_mode got=%0d exp=0", core_mode_o); end
    if (core_data_o !== '0) begin errors++; $display("FAIL rst_core_data got=%h exp=0", core_data_o); end
    if (core_key_o !== '0) begin errors++; $display("FAIL rst_core_key got=%h exp=0", core_key_o); end
    req_valid_i = '0;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_single();
    int start = resp_cnt;
    int a0 = acc_cnt[0];
    set_req(0, PT, K128, ENC_128);
    wait_resp(start + 1, 200, "single");
    repeat (5) step();
    checks += 3;
    if (acc_cnt[0] - a0 != 1) begin errors++; $display("FAIL single_accepts got=%0d exp=1", acc_cnt[0] - a0); end
    if (resp_order[resp_order.size() - 1] != 0) begin errors++; $display("FAIL single_id got=%0d exp=0", resp_order[resp_order.size() - 1]); end
    if (last_resp_data !== C128) begin errors++; $display("FAIL single_data got=%h exp=%h", last_resp_data, C128); end
  endtask

  task automatic test_noop_skip();
    int start = resp_cnt;
    int a0 = acc_cnt[0];
    set_req(0, PT, K128, NOOP);
    set_req(3, PT, K128, ENC_128);
    wait_resp(start + 1, 200, "noop");
    repeat (6) step();
    checks += 3;
    if (resp_order[resp_order.size() - 1] != 3) begin errors++; $display("FAIL noop_id got=%0d exp=3", resp_order[resp_order.size() - 1]); end
    if (acc_cnt[0] != a0) begin errors++; $display("FAIL noop_accepted got=%0d exp=%0d", acc_cnt[0], a0); end
    if (resp_cnt != start + 1) begin errors++; $display("FAIL noop_resp_count got=%0d exp=%0d", resp_cnt, start + 1); end
    req_valid_i[0] = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_ids [5] = '{0, 1, 2, 3, 1};
    int start = resp_cnt;
    int base = resp_order.size();
    logic raised = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, PT, K256, ENC_256);
    for (int n = 0; n < 600 && resp_cnt < start + 5; n++) begin
      step();
      if (!raised && resp_cnt >= start + 2) begin
        set_req(1, PT, K256, ENC_256);
        raised = 1'b1;
      end
    end
    checks++;
    if (resp_cnt < start + 5) begin
      errors++;
      $display("FAIL rr_timeout got=%0d responses exp=%0d", resp_cnt - start, 5);
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (resp_order[base + j] != exp_ids[j]) begin
          errors++;
          $display("FAIL rr_order_%0d got=%0d exp=%0d", j, resp_order[base + j], exp_ids[j]);
        end
      end
    end
    checks++;
    if (last_resp_data !== C256) begin errors++; $display("FAIL rr_data got=%h exp=%h", last_resp_data, C256); end
  endtask

  task automatic test_backpressure();
    int start = resp_cnt;
    int a0;
    int n;
    resp_ready_i = 1'b0;
    set_req(2, PT, K192, ENC_192);
    for (n = 0; n < 200 && !resp_valid_o; n++) step();
    rand_req(0, ENC_128);
    a0 = acc_cnt[0];
    for (int c = 0; c < 5; c++) begin
      step();
      checks += 4;
      if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got=%b exp=1", c, resp_valid_o); end
      if (resp_data_o !== C192) begin errors++; $display("FAIL bp_data_%0d got=%h exp=%h", c, resp_data_o, C192); end
      if (resp_id_o !== 2'd2) begin errors++; $display("FAIL bp_id_%0d got=%0d exp=2", c, resp_id_o); end
      if (acc_cnt[0] != a0) begin errors++; $display("FAIL bp_accept_%0d got=%0d exp=%0d", c, acc_cnt[0], a0); end
    end
    resp_ready_i = 1'b1;
    wait_resp(start + 2, 200, "bp");
    checks++;
    if (resp_order[resp_order.size() - 1] != 0) begin errors++; $display("FAIL bp_next_id got=%0d exp=0", resp_order[resp_order.size() - 1]); end
  endtask

  task automatic test_random();
    int start = resp_cnt;
    spur_en = 1'b1;
    for (int n = 0; n < 800; n++) begin
      step();
      resp_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i] && $urandom_range(0, 3) == 0) rand_req(i, mode_e'($urandom_range(0, 3)));
        else if (req_valid_i[i] && req_mode_i[i] == NOOP && $urandom_range(0, 7) == 0) req_valid_i[i] = 1'b0;
      end
    end
    resp_ready_i = 1'b1;
    for (int i = 0; i < N; i++) if (req_mode_i[i] == NOOP) req_valid_i[i] = 1'b0;
    for (int n = 0; n < 400 && (m_busy || req_valid_i != '0); n++) step();
    spur_en = 1'b0;
    checks += 2;
    if (m_busy || req_valid_i != '0) begin errors++; $display("FAIL rand_drain got=busy exp=idle"); end
    if (resp_cnt - start < 20) begin errors++; $display("FAIL rand_progress got=%0d exp>=20", resp_cnt - start); end
  endtask

  task automatic test_reset_busy();
    int start;
    core_hold = 1'b1;
    rand_req(0, ENC_256);
    for (int n = 0; n < 200 && !core_busy; n++) step();
    set_req(1, PT, K128, ENC_128);
    rst = 1'b1;
    core_busy = 1'b0;
    core_hold = 1'b0;
    #2;
    checks += 7;
    if (req_ready_o !== '0) begin errors++; $display("FAIL rb_ready got=%b exp=0", req_ready_o); end
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rb_resp_valid got=%b exp=0", resp_valid_o); end
    if (resp_data_o !== '0) begin errors++; $display("FAIL rb_resp_data got=%h exp=0", resp_data_o); end
    if (resp_id_o !== '0) begin errors++; $display("FAIL rb_resp_id got=%0d exp=0", resp_id_o); end
    if (core_mode_o !== NOOP) begin errors++; $display("FAIL rb_core_mode got=%0d exp=0", core_mode_o); end
    if (core_data_o !== '0) begin errors++; $display("FAIL rb_core_data got=%h exp=0", core_data_o); end
    if (core_key_o !== '0) begin errors++; $display("FAIL rb_core_key got=%h exp=0", core_key_o); end
    m_busy = 1'b0;
    m_ptr = 0;
    req_valid_i = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    start = resp_cnt;
    set_req(0, PT, K128, ENC_128);
    wait_resp(start + 1, 200, "rb");
    checks += 2;
    if (resp_order[resp_order.size() - 1] != 0) begin errors++; $display("FAIL rb_id got=%0d exp=0", resp_order[resp_order.size() - 1]); end
    if (last_resp_data !== C128) begin errors++; $display("FAIL rb_data got=%h exp=%h", last_resp_data, C128); end
  endtask

`ifdef AES_REQ_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int start = resp_cnt;
    int n;
    expect_to = 1'b1;
    core_hold = 1'b1;
    rand_req(3, ENC_256);
    for (n = 0; n < 200 && !core_busy; n++) step();
    for (n = 0; n < TO + 20 && !resp_valid_o; n++) step();
    checks += 3;
    if (n != TO) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", n, TO); end
    if (resp_err_o !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", resp_err_o); end
    if (resp_data_o !== '0) begin errors++; $display("FAIL to_data got=%h exp=0", resp_data_o); end
    wait_resp(start + 1, 50, "to");
    core_busy = 1'b0;
    core_hold = 1'b0;
    expect_to = 1'b0;
  endtask
`endif

  initial begin
    req_valid_i  = '0;
    req_data_i   = '0;
    req_key_i    = '0;
    for (int i = 0; i < N; i++) req_mode_i[i] = NOOP;
    resp_ready_i = 1'b1;
    test_reset();
    test_single();
    test_noop_skip();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_busy();
`ifdef AES_REQ_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
